// File: rtl/microwave_pkg.sv
// Shared types and limits for the microwave cook-timer datapath.
package microwave_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cook_state_t;

    localparam int MIN_W = 7;
    localparam int SEC_W = 6;
    localparam int PWR_W = 8;

    localparam logic [MIN_W-1:0] MAX_MIN = 7'd99;
    localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;

    function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] m);
        return (m > MAX_MIN) ? MAX_MIN : m;
    endfunction

    function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
        return (s > MAX_SEC) ? MAX_SEC : s;
    endfunction

endpackage

// File: rtl/cook_timer_if.sv
// Control/status bundle between the front panel / stop logic and cook_timer.
interface cook_timer_if;
    import microwave_pkg::*;

    logic             load;
    logic [MIN_W-1:0] set_min;
    logic [SEC_W-1:0] set_sec;
    logic [PWR_W-1:0] power_in;
    logic             start;
    logic             door_open;
    logic             clear_timer_signal;
    logic             microwave_power_off_signal;
    logic             microwave_power_on;
    logic [PWR_W-1:0] power_level;
    logic [MIN_W-1:0] rem_min;
    logic [SEC_W-1:0] rem_sec;
    logic             busy;
    logic             done;
    logic             beep;

    modport master (
        output load, set_min, set_sec, power_in, start, door_open,
               clear_timer_signal, microwave_power_off_signal,
        input  microwave_power_on, power_level, rem_min, rem_sec, busy, done, beep
    );

    modport slave (
        input  load, set_min, set_sec, power_in, start, door_open,
               clear_timer_signal, microwave_power_off_signal,
        output microwave_power_on, power_level, rem_min, rem_sec, busy, done, beep
    );

endinterface

// File: rtl/sec_prescaler.sv
// Counts 0..TICKS_PER_SEC-1 while enabled; o_wrap marks the last count of each second.
module sec_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap
);

    localparam int unsigned          CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wrap ignores i_clr so the caller may derive i_clr from o_wrap-free logic only.
    assign o_wrap = i_en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cook_timer.sv
// mm:ss countdown cook timer driving the magnetron enable and power level.
// Optional completion beeper is built only when MW_BEEP_EN is defined.
module cook_timer
    import microwave_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned BEEP_SECONDS  = 3
) (
    input  logic          clk,
    input  logic          rst,
    cook_timer_if.slave   bus
);

    cook_state_t      r_state, w_state_nx;
    logic [MIN_W-1:0] r_min, w_min_nx, w_dec_min;
    logic [SEC_W-1:0] r_sec, w_sec_nx, w_dec_sec;
    logic [PWR_W-1:0] r_pwr, w_pwr_nx;
    logic             r_pon, r_busy, r_done;
    logic [PWR_W-1:0] r_plvl;
    logic             w_done_nx, w_ps_clr, w_ps_en, w_ps_wrap;
    logic             w_can_run, w_halt, w_time_zero;

    // Parameter sanity bound; a legal configuration generates nothing here.
    if (TICKS_PER_SEC < 2 || BEEP_SECONDS > 255) begin : g_bad_cfg
    end

    assign w_halt      = bus.door_open || bus.microwave_power_off_signal;
    assign w_can_run   = !w_halt;
    assign w_time_zero = (r_min == '0) && (r_sec == '0);
    // Counting every RUN cycle (including the one that pauses) keeps total heat time exact.
    assign w_ps_en     = (r_state == RUN);

    sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_ps (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_ps_en),
        .i_clr  (w_ps_clr),
        .o_wrap (w_ps_wrap)
    );

    always_comb begin
        w_dec_min = r_min;
        w_dec_sec = r_sec - SEC_W'(1);
        if (r_sec == '0) begin
            w_dec_min = r_min - MIN_W'(1);
            w_dec_sec = MAX_SEC;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_min_nx   = r_min;
        w_sec_nx   = r_sec;
        w_pwr_nx   = r_pwr;
        w_ps_clr   = 1'b0;
        w_done_nx  = 1'b0;
        if (bus.clear_timer_signal) begin
            w_state_nx = IDLE;
            w_min_nx   = '0;
            w_sec_nx   = '0;
            w_pwr_nx   = '0;
            w_ps_clr   = 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.load) begin
                        w_state_nx = IDLE;
                        w_min_nx   = clamp_min(bus.set_min);
                        w_sec_nx   = clamp_sec(bus.set_sec);
                        w_pwr_nx   = bus.power_in;
                    end else if (r_state == IDLE && bus.start && !w_time_zero && w_can_run) begin
                        w_state_nx = RUN;
                        w_ps_clr   = 1'b1;
                    end
                end
                PAUSE: begin
                    if (bus.start && w_can_run) w_state_nx = RUN;
                end
                RUN: begin
                    if (w_ps_wrap) begin
                        w_min_nx = w_dec_min;
                        w_sec_nx = w_dec_sec;
                        if (w_dec_min == '0 && w_dec_sec == '0) begin
                            w_state_nx = DONE;
                            w_done_nx  = 1'b1;
                        end
                    end
                    // A halt pauses unless this very edge finished the countdown.
                    if (w_halt && w_state_nx == RUN) w_state_nx = PAUSE;
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_min   <= '0;
            r_sec   <= '0;
            r_pwr   <= '0;
            r_pon   <= 1'b0;
            r_plvl  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_min   <= w_min_nx;
            r_sec   <= w_sec_nx;
            r_pwr   <= w_pwr_nx;
            r_pon   <= (w_state_nx == RUN);
            r_plvl  <= (w_state_nx == RUN) ? w_pwr_nx : '0;
            r_busy  <= (w_state_nx == RUN) || (w_state_nx == PAUSE);
            r_done  <= w_done_nx;
        end
    end

    assign bus.microwave_power_on = r_pon;
    assign bus.power_level        = r_plvl;
    assign bus.rem_min            = r_min;
    assign bus.rem_sec            = r_sec;
    assign bus.busy               = r_busy;
    assign bus.done               = r_done;

`ifdef MW_BEEP_EN
    localparam int unsigned BEEP_W = $clog2(BEEP_SECONDS + 1);

    logic              r_beep;
    logic [BEEP_W-1:0] r_beep_left;
    logic              w_beep_wrap, w_beep_stop;

    assign w_beep_stop = bus.clear_timer_signal ||
                         (bus.load && (r_state == IDLE || r_state == DONE));

    sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_beep_ps (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_beep),
        .i_clr  (w_done_nx),
        .o_wrap (w_beep_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst || w_beep_stop) begin
            r_beep      <= 1'b0;
            r_beep_left <= '0;
        end else if (w_done_nx) begin
            r_beep      <= 1'b1;
            r_beep_left <= BEEP_W'(BEEP_SECONDS);
        end else if (r_beep && w_beep_wrap) begin
            if (r_beep_left <= BEEP_W'(1)) r_beep <= 1'b0;
            r_beep_left <= r_beep_left - BEEP_W'(1);
        end
    end

    assign bus.beep = r_beep;
`else
    assign bus.beep = 1'b0;
`endif

endmodule
